// File: rtl/data_mem_bridge_if.sv
// Bus bundle between the core memory stage, the data_mem_bridge and the memory data port.
// The master modport is the environment (core + memory); the slave modport is the bridge.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

interface data_mem_bridge_if #(
  parameter int DATA_BITS = `DATA_BITS
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [DATA_BITS-1:0]   req_addr;
  logic [31:0]            req_wdata;
  logic                   resp_valid;
  logic [31:0]            resp_rdata;
  logic                   resp_err;
  logic [DATA_BITS-3:0]   mem_addr;
  logic                   mem_ren;
  logic                   mem_wen;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_bsv;
  logic [31:0]            mem_rdata;
  logic                   mem_ready;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_ren, mem_wen, mem_wdata, mem_bsv
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_ren, mem_wen, mem_wdata, mem_bsv
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Load/store bridge: turns one byte/half/word core request into memory strobes and
// returns extended load data, a write acknowledge, or a misalign/timeout error.
//
//   state      | meaning
//   S_IDLE     | req_ready=1, waiting for a request
//   S_WR       | mem_wen strobe cycle
//   S_RD_ISSUE | mem_ren strobe cycle (mem_ready not sampled here)
//   S_RD_WAIT  | waiting for mem_ready, timeout counter running
//   S_DONE     | resp_valid pulse
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module data_mem_bridge #(
  parameter int DATA_BITS = `DATA_BITS,
  parameter int TIMEOUT   = 64
) (
  input logic               clk,
  input logic               reset,
  data_mem_bridge_if.slave  bus
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [1:0]           lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-3:0] mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_bsv_q, mem_bsv_d;
  logic                 mem_ren_q, mem_ren_d;
  logic                 mem_wen_q, mem_wen_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;

  logic [3:0]           bsv_lanes;
  logic [31:0]          wdata_lanes;
  logic                 misaligned;
  logic [15:0]          lane_h;
  logic [7:0]           lane_b;
  logic [31:0]          load_ext;

  // Request decode: lane enables and replicated store data; size 11 behaves as a word.
  always_comb begin
    bsv_lanes   = 4'b1111;
    wdata_lanes = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        bsv_lanes   = 4'b0001 << bus.req_addr[1:0];
        wdata_lanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        bsv_lanes   = 4'b0011 << bus.req_addr[1:0];
        wdata_lanes = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        bsv_lanes   = 4'b1111;
        wdata_lanes = bus.req_wdata;
      end
    endcase
    misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
  end

  always_comb begin
    lane_h = bus.mem_rdata[{lo_q[1], 4'b0000} +: 16];
    lane_b = bus.mem_rdata[{lo_q, 3'b000} +: 8];
    if (size_q[1]) begin
      load_ext = bus.mem_rdata;
    end else if (size_q[0]) begin
      load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
    end else begin
      load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
    end
  end

  // Outputs are computed for the state being entered so that every output is a flop.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_bsv_d    = 4'b0000;
    mem_ren_d    = 1'b0;
    mem_wen_d    = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          size_d      = bus.req_size;
          uns_d       = bus.req_unsigned;
          lo_d        = bus.req_addr[1:0];
          mem_addr_d  = bus.req_addr[DATA_BITS-1:2];
          mem_wdata_d = wdata_lanes;
          if (misaligned) begin
            state_d    = S_DONE;
            resp_err_d = 1'b1;
          end else if (bus.req_we) begin
            state_d   = S_WR;
            mem_wen_d = 1'b1;
            mem_bsv_d = bsv_lanes;
          end else begin
            state_d   = S_RD_ISSUE;
            mem_ren_d = 1'b1;
          end
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        cnt_d   = '0;
      end
      S_RD_WAIT: begin
        if (bus.mem_ready) begin
          state_d      = S_DONE;
          resp_rdata_d = load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          resp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    resp_valid_d = (state_d == S_DONE);
    req_ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lo_q         <= 2'b00;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_bsv_q    <= 4'b0000;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_bsv_q    <= mem_bsv_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_bsv    = mem_bsv_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: a 7-cycle-ready memory model plus a
// byte-array reference model for randomized load/store traffic.
module tb_data_mem_bridge;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  data_mem_bridge_if #(.DATA_BITS(16)) bus ();

  data_mem_bridge #(.DATA_BITS(16), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write on wen, ready drops on ren and returns after 7 cycles.
  logic [31:0] words [64];
  logic        mem_ready_r;
  logic [31:0] rdata_r;
  int          rd_cnt;
  bit          hang;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_r <= 1'b1;
      rd_cnt      <= 0;
      rdata_r     <= 32'h0;
      for (int i = 0; i < 64; i++) words[i] <= 32'h0;
    end else begin
      if (bus.mem_wen)
        for (int k = 0; k < 4; k++)
          if (bus.mem_bsv[k]) words[bus.mem_addr[5:0]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
      if (bus.mem_ren) begin
        mem_ready_r <= 1'b0;
        rd_cnt      <= 7;
        rdata_r     <= words[bus.mem_addr[5:0]];
      end else if (!mem_ready_r && !hang) begin
        if (rd_cnt == 1) mem_ready_r <= 1'b1;
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  assign bus.mem_ready = mem_ready_r;
  assign bus.mem_rdata = mem_ready_r ? rdata_r : 32'hA5A5_A5A5;

  // Protocol monitor
  int viol = 0;
  bit outstanding = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (bus.mem_ren && bus.mem_wen) viol++;
      if (!bus.mem_wen && bus.mem_bsv != 4'b0000) viol++;
      if (outstanding && (bus.mem_ren || bus.mem_wen)) viol++;
      if (bus.mem_ren) outstanding = 1;
      if (bus.resp_valid) outstanding = 0;
    end
  end

  // Observations of the last transaction
  int          lat, wn, rn;
  logic [31:0] rd, ws;
  logic        er;
  logic [3:0]  bs;
  logic [13:0] ma;

  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [15:0] addr, input logic [31:0] wd, input bit hold);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
    lat = 0; wn = 0; rn = 0; rd = 32'h0; er = 1'b0; bs = 4'h0; ws = 32'h0;
    ma = bus.mem_addr;
    for (int c = 1; c <= 200; c++) begin
      if (bus.mem_wen) begin wn++; bs = bus.mem_bsv; ws = bus.mem_wdata; end
      if (bus.mem_ren) rn++;
      if (bus.resp_valid) begin lat = c; rd = bus.resp_rdata; er = bus.resp_err; break; end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (lat != 0) begin @(posedge clk); #1; end
  endtask

  // Reference model: byte-addressed memory and spec-level rules
  logic [7:0] ref_mem [256];

  task automatic ref_xact(input logic we, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wd,
                          output int e_lat, output logic e_err, output logic [31:0] e_rd,
                          output logic [3:0] e_bsv, output logic [31:0] e_wd, output bit e_mis);
    int nb;
    logic [31:0] v;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e_mis = (addr % nb) != 0;
    e_err = e_mis; e_rd = 32'h0; e_bsv = 4'h0; e_wd = 32'h0;
    if (e_mis) begin
      e_lat = 1;
    end else if (we) begin
      e_lat = 2;
      for (int i = 0; i < nb; i++) ref_mem[(addr + i) % 256] = wd[8*i +: 8];
      e_bsv = 4'((((1 << nb) - 1) << (addr % 4)));
      e_wd  = (nb == 1) ? wd[7:0] * 32'h0101_0101 : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    end else begin
      e_lat = 10;
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(addr + i) % 256]) << (8 * i));
      if (nb < 4 && !uns && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
      e_rd = v;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hang = 0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end checks++;
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); end checks++;
    if ({bus.mem_ren, bus.mem_wen} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {bus.mem_ren, bus.mem_wen}); end checks++;
    if (bus.mem_bsv !== 4'h0) begin errors++; $display("FAIL rst_bsv got %h exp 0", bus.mem_bsv); end checks++;
    if ({bus.resp_rdata, bus.resp_err} !== 33'h0) begin errors++; $display("FAIL rst_resp got %h/%b exp 0", bus.resp_rdata, bus.resp_err); end checks++;
  endtask

  task automatic test_word();
    xact(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEAD_BEEF, 0);
    if (ma !== 14'd4) begin errors++; $display("FAIL sw_addr got %0d exp 4", ma); end checks++;
    if (bs !== 4'b1111) begin errors++; $display("FAIL sw_bsv got %b exp 1111", bs); end checks++;
    if (wn !== 1 || rn !== 0) begin errors++; $display("FAIL sw_strobes got wen=%0d ren=%0d exp 1/0", wn, rn); end checks++;
    if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got lat=%0d err=%b exp 2/0", lat, er); end checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready_after got %b exp 1", bus.req_ready); end checks++;
    xact(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 0);
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rd); end checks++;
    if (lat !== 10 || er !== 1'b0) begin errors++; $display("FAIL lw_resp got lat=%0d err=%b exp 10/0", lat, er); end checks++;
    if (rn !== 1 || wn !== 0) begin errors++; $display("FAIL lw_strobes got ren=%0d wen=%0d exp 1/0", rn, wn); end checks++;
  endtask

  task automatic test_byte();
    xact(1'b1, 2'b00, 1'b0, 16'h0013, 32'h0000_0080, 0);
    if (bs !== 4'b1000) begin errors++; $display("FAIL sb_bsv got %b exp 1000", bs); end checks++;
    if (ws !== 32'h8080_8080) begin errors++; $display("FAIL sb_wdata got %h exp 80808080", ws); end checks++;
    xact(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 0);
    if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", rd); end checks++;
    xact(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 0);
    if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lb_unsigned got %h exp 00000080", rd); end checks++;
    xact(1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, 0);
    if (rd !== 32'h0000_00BE) begin errors++; $display("FAIL lb_lane1 got %h exp 000000be", rd); end checks++;
  endtask

  task automatic test_half();
    xact(1'b1, 2'b10, 1'b0, 16'h0020, 32'h8001_1234, 0);
    xact(1'b1, 2'b01, 1'b0, 16'h0022, 32'hFFFF_8001, 0);
    if (bs !== 4'b1100) begin errors++; $display("FAIL sh_bsv got %b exp 1100", bs); end checks++;
    if (ws !== 32'h8001_8001) begin errors++; $display("FAIL sh_wdata got %h exp 80018001", ws); end checks++;
    xact(1'b0, 2'b01, 1'b0, 16'h0022, 32'h0, 0);
    if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_signed got %h exp ffff8001", rd); end checks++;
    xact(1'b0, 2'b01, 1'b1, 16'h0022, 32'h0, 0);
    if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lh_unsigned got %h exp 00008001", rd); end checks++;
    xact(1'b0, 2'b01, 1'b0, 16'h0020, 32'h0, 0);
    if (rd !== 32'h0000_1234) begin errors++; $display("FAIL lh_low got %h exp 00001234", rd); end checks++;
  endtask

  task automatic test_misaligned();
    xact(1'b0, 2'b10, 1'b0, 16'h0006, 32'h0, 0);
    if (rn !== 0 || wn !== 0) begin errors++; $display("FAIL mis_lw_strobes got ren=%0d wen=%0d exp 0/0", rn, wn); end checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_lw_resp got lat=%0d err=%b rd=%h exp 1/1/0", lat, er, rd); end checks++;
    xact(1'b1, 2'b01, 1'b0, 16'h0021, 32'h1234_5678, 0);
    if (wn !== 0 || lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL mis_sh got wen=%0d lat=%0d err=%b exp 0/1/1", wn, lat, er); end checks++;
    xact(1'b0, 2'b11, 1'b0, 16'h0022, 32'h0, 0);
    if (er !== 1'b1 || lat !== 1) begin errors++; $display("FAIL mis_size3 got lat=%0d err=%b exp 1/1", lat, er); end checks++;
  endtask

  task automatic test_held_valid();
    xact(1'b1, 2'b10, 1'b0, 16'h0040, 32'h0BAD_F00D, 1);
    if (wn !== 1 || lat !== 2) begin errors++; $display("FAIL held_store got wen=%0d lat=%0d exp 1/2", wn, lat); end checks++;
    xact(1'b0, 2'b11, 1'b0, 16'h0040, 32'h0, 1);
    if (rn !== 1 || rd !== 32'h0BAD_F00D || lat !== 10) begin errors++; $display("FAIL held_load got ren=%0d rd=%h lat=%0d exp 1/0badf00d/10", rn, rd, lat); end checks++;
  endtask

  task automatic test_random();
    logic        we, uns, e_err;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [31:0] wd, e_rd, e_wd;
    logic [3:0]  e_bsv;
    int          e_lat;
    bit          e_mis;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int n = 0; n < 60; n++) begin
      we   = (n < 12) ? 1'b1 : 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = 16'(128 + $urandom_range(0, 127));
      if ($urandom_range(0, 2) != 0 && size != 2'b00) addr = addr & (size[1] ? 16'hFFFC : 16'hFFFE);
      wd   = $urandom;
      ref_xact(we, size, uns, addr, wd, e_lat, e_err, e_rd, e_bsv, e_wd, e_mis);
      xact(we, size, uns, addr, wd, 0);
      if (lat !== e_lat || er !== e_err) begin errors++; $display("FAIL rnd%0d_resp got lat=%0d err=%b exp %0d/%b", n, lat, er, e_lat, e_err); end checks++;
      if (rd !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, rd, e_rd); end checks++;
      if (ma !== addr[15:2]) begin errors++; $display("FAIL rnd%0d_addr got %h exp %h", n, ma, addr[15:2]); end checks++;
      if (e_mis) begin
        if (wn + rn !== 0) begin errors++; $display("FAIL rnd%0d_mis_strobe got %0d exp 0", n, wn + rn); end checks++;
      end else if (we) begin
        if (wn !== 1 || bs !== e_bsv || ws !== e_wd) begin errors++; $display("FAIL rnd%0d_store got wen=%0d bsv=%b wd=%h exp 1/%b/%h", n, wn, bs, ws, e_bsv, e_wd); end checks++;
      end else begin
        if (rn !== 1 || wn !== 0) begin errors++; $display("FAIL rnd%0d_load_strobe got ren=%0d wen=%0d exp 1/0", n, rn, wn); end checks++;
      end
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready got %b exp 1", n, bus.req_ready); end checks++;
    end
  endtask

  task automatic test_timeout();
    hang = 1;
    xact(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 0);
    if (lat !== 66 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL timeout got lat=%0d err=%b rd=%h exp 66/1/0", lat, er, rd); end checks++;
  endtask

  task automatic test_reset_mid_read();
    int pulses;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 16'h0014;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.req_ready); end checks++;
    if ({bus.resp_valid, bus.resp_err, bus.mem_ren, bus.mem_wen, bus.mem_bsv} !== 8'h0) begin errors++; $display("FAIL midrst_ctrl got %b exp 0", {bus.resp_valid, bus.resp_err, bus.mem_ren, bus.mem_wen, bus.mem_bsv}); end checks++;
    if ({bus.resp_rdata, bus.mem_wdata, bus.mem_addr} !== 78'h0) begin errors++; $display("FAIL midrst_data got %h/%h/%h exp 0", bus.resp_rdata, bus.mem_wdata, bus.mem_addr); end checks++;
    hang = 0;
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (80) begin @(negedge clk); if (bus.resp_valid) pulses++; end
    if (pulses !== 0) begin errors++; $display("FAIL midrst_no_resp got %0d exp 0", pulses); end checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got %b exp 1", bus.req_ready); end checks++;
  endtask

  task automatic test_protocol();
    if (viol !== 0) begin errors++; $display("FAIL protocol_violations got %0d exp 0", viol); end checks++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_held_valid();
    test_random();
    test_timeout();
    test_reset_mid_read();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
